// File: rtl/rx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rx_queue
//  Description : 10G MAC RX word stream to AXI4-Stream master. Frames are
//                staged into a packet FIFO and released only once they end
//                good; bad, malformed and overflowing frames are rolled back
//                and counted in a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_queue #(
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int FIFO_ADDR_WIDTH  = 9,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AXI_DATA_WIDTH-1:0]   rx_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] rx_data_valid,
  input  logic                        rx_good_frame,
  input  logic                        rx_bad_frame,
  output logic [AXI_DATA_WIDTH-1:0]   tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] tstrb,
  output logic                        tvalid,
  output logic                        tlast,
  input  logic                        tready,
  output logic [DROP_COUNT_WIDTH-1:0] pkt_drop_count
);

  localparam int KW    = AXI_DATA_WIDTH / 8;
  localparam int PW    = FIFO_ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int EW    = 1 + KW + AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_RECV = 2'd2,
    ST_DROP = 2'd3
  } wstate_t;

  wstate_t                     state_q, state_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               wr_commit_q, wr_commit_d;
  logic [PW-1:0]               rd_ptr_q;
  logic [AXI_DATA_WIDTH-1:0]   stg_data_q, stg_data_d;
  logic [KW-1:0]               stg_strb_q, stg_strb_d;
  logic                        good_q, bad_q;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [AXI_DATA_WIDTH-1:0]   tdata_q;
  logic [KW-1:0]               tstrb_q;
  logic                        tvalid_q, tlast_q;
  logic [EW-1:0]               mem_q [DEPTH];

  logic          w_beat, w_legal, w_full, w_empty, w_load;
  logic          w_mem_we, w_drop_inc;
  logic [EW-1:0] w_mem_wdata, w_rd_word;
  logic [KW:0]   w_mask_p1;

  // Beat qualification: a legal mask is a contiguous run of ones from byte 0.
  always_comb begin
    w_beat    = |rx_data_valid;
    w_mask_p1 = {1'b0, rx_data_valid} + {{KW{1'b0}}, 1'b1};
    w_legal   = w_beat && ((rx_data_valid & w_mask_p1[KW-1:0]) == '0);
    w_full    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    w_empty   = (rd_ptr_q == wr_commit_q);
    w_load    = !w_empty && (!tvalid_q || tready);
    w_rd_word = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
  end

  // Write FSM: the delayed status pulse is resolved first, then the current
  // beat, so a status that shared a cycle with a beat is seen after it.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    stg_data_d  = stg_data_q;
    stg_strb_d  = stg_strb_q;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    w_drop_inc  = 1'b0;

    if (state_q == ST_SYNC) begin
      if (!w_beat && !rx_good_frame && !rx_bad_frame) state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (good_q) begin
            if (w_full) begin
              wr_ptr_d   = wr_commit_q;
              w_drop_inc = 1'b1;
            end else begin
              w_mem_we    = 1'b1;
              w_mem_wdata = {1'b1, stg_strb_q, stg_data_q};
              wr_ptr_d    = wr_ptr_q + 1'b1;
              wr_commit_d = wr_ptr_q + 1'b1;
            end
            state_d = ST_IDLE;
          end else if (bad_q) begin
            wr_ptr_d   = wr_commit_q;
            w_drop_inc = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (good_q || bad_q) begin
            w_drop_inc = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: ;
      endcase

      if (w_beat) begin
        case (state_d)
          ST_IDLE: begin
            if (!w_legal) begin
              state_d = ST_DROP;
            end else begin
              stg_data_d = rx_data;
              stg_strb_d = rx_data_valid;
              state_d    = ST_RECV;
            end
          end
          ST_RECV: begin
            // Only the final beat may be partial; anything odd aborts the frame.
            if (!w_legal || (stg_strb_q != '1) || w_full) begin
              wr_ptr_d = wr_commit_q;
              state_d  = ST_DROP;
            end else begin
              w_mem_we    = 1'b1;
              w_mem_wdata = {1'b0, stg_strb_q, stg_data_q};
              wr_ptr_d    = wr_ptr_q + 1'b1;
              stg_data_d  = rx_data;
              stg_strb_d  = rx_data_valid;
            end
          end
          default: ;
        endcase
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (w_drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Write-side state, pointers, staging register and status delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SYNC;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      stg_data_q  <= '0;
      stg_strb_q  <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      stg_data_q  <= stg_data_d;
      stg_strb_q  <= stg_strb_d;
      good_q      <= rx_good_frame && (state_q != ST_SYNC);
      bad_q       <= rx_bad_frame && (state_q != ST_SYNC);
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Packet FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= w_mem_wdata;
  end

  // Prefetching AXI output register: refills whenever empty or being drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (w_load) begin
      {tlast_q, tstrb_q, tdata_q} <= w_rd_word;
      tvalid_q <= 1'b1;
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end else if (tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign tdata          = tdata_q;
  assign tstrb          = tstrb_q;
  assign tlast          = tlast_q;
  assign tvalid         = tvalid_q;
  assign pkt_drop_count = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_queue
//  Description : Directed self-checking bench for rx_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] rx_data = '0;
  logic [7:0]  rx_data_valid = '0;
  logic        rx_good_frame = 1'b0;
  logic        rx_bad_frame = 1'b0;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b1;
  logic        tready_req = 1'b1;
  logic        tog_en = 1'b0;
  logic [15:0] pkt_drop_count;

  int n_vec = 0;
  int n_err = 0;

  logic [72:0] exp_q[$];
  logic        hold = 1'b0;
  logic [72:0] held = '0;

  rx_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_good_frame  (rx_good_frame),
    .rx_bad_frame   (rx_bad_frame),
    .tdata          (tdata),
    .tstrb          (tstrb),
    .tvalid         (tvalid),
    .tlast          (tlast),
    .tready         (tready),
    .pkt_drop_count (pkt_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int f, input int b);
    return {8'hD0 ^ 8'(f), 8'(f), 16'(b), 16'(f * 7 + b), 16'hBEEF ^ 16'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m);
    rx_data       = d;
    rx_data_valid = m;
    tick();
    rx_data       = '0;
    rx_data_valid = '0;
  endtask

  task automatic pulse(input logic good, input logic bad);
    rx_good_frame = good;
    rx_bad_frame  = bad;
    tick();
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input logic [7:0] lastm,
                            input logic good, input logic push);
    logic [7:0] m;
    for (int b = 0; b < n; b++) begin
      m = (b == n - 1) ? lastm : 8'hFF;
      if (push) exp_q.push_back({(b == n - 1), m, mkword(f, b)});
      send_beat(mkword(f, b), m);
    end
    pulse(good, !good);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    chk({"drain ", tag}, 96'(exp_q.size()), 96'(0));
  endtask

  // tready source: fixed level from the stimulus, or toggling every cycle.
  always @(posedge clk) begin
    #2;
    tready = tog_en ? ~tready : tready_req;
  end

  // Output monitor: in-order scoreboard plus hold-stability under backpressure.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold tvalid", 96'(tvalid), 96'(1));
        chk("hold word", 96'({tlast, tstrb, tdata}), 96'(held));
      end
      if (tvalid && tready) begin
        chk("beat expected", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0) chk("beat word", 96'({tlast, tstrb, tdata}), 96'(exp_q.pop_front()));
        hold = 1'b0;
      end else if (tvalid) begin
        hold = 1'b1;
        held = {tlast, tstrb, tdata};
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst tvalid", 96'(tvalid), 96'(0));
    chk("rst tlast", 96'(tlast), 96'(0));
    chk("rst tdata", 96'(tdata), 96'(0));
    chk("rst tstrb", 96'(tstrb), 96'(0));
    chk("rst count", 96'(pkt_drop_count), 96'(0));
    reset_n = 1'b1;
    repeat (2) tick();

    // 1) 3-beat good frame, latency and back-to-back delivery
    exp_q.push_back({1'b0, 8'hFF, mkword(1, 0)});
    exp_q.push_back({1'b0, 8'hFF, mkword(1, 1)});
    exp_q.push_back({1'b1, 8'h0F, mkword(1, 2)});
    send_beat(mkword(1, 0), 8'hFF);
    send_beat(mkword(1, 1), 8'hFF);
    send_beat(mkword(1, 2), 8'h0F);
    pulse(1'b1, 1'b0);
    chk("t1 lat N", 96'(tvalid), 96'(0));
    tick();
    chk("t1 lat N+1", 96'(tvalid), 96'(0));
    tick();
    chk("t1 beat0 valid", 96'(tvalid), 96'(1));
    chk("t1 beat0 last", 96'(tlast), 96'(0));
    tick();
    chk("t1 beat1 valid", 96'(tvalid), 96'(1));
    tick();
    chk("t1 beat2 valid", 96'(tvalid), 96'(1));
    chk("t1 beat2 last", 96'(tlast), 96'(1));
    chk("t1 beat2 strb", 96'(tstrb), 96'(8'h0F));
    tick();
    chk("t1 idle after", 96'(tvalid), 96'(0));

    // 2) bad frame dropped, then 1-beat good frame with same-cycle status
    send_frame(2, 2, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("t2 count", 96'(pkt_drop_count), 96'(1));
    exp_q.push_back({1'b1, 8'h01, mkword(3, 0)});
    rx_data       = mkword(3, 0);
    rx_data_valid = 8'h01;
    rx_good_frame = 1'b1;
    tick();
    rx_data       = '0;
    rx_data_valid = '0;
    rx_good_frame = 1'b0;
    wait_drain("t2");

    // 4) malformed frames: illegal mask, partial beat followed by another
    send_beat(mkword(4, 0), 8'h05);
    pulse(1'b1, 1'b0);
    repeat (2) tick();
    chk("t4 mask05 count", 96'(pkt_drop_count), 96'(2));
    send_beat(mkword(4, 1), 8'hFF);
    send_beat(mkword(4, 2), 8'h0F);
    send_beat(mkword(4, 3), 8'hFF);
    pulse(1'b1, 1'b0);
    repeat (2) tick();
    chk("t4 ff0fff count", 96'(pkt_drop_count), 96'(3));
    send_frame(5, 2, 8'h7F, 1'b1, 1'b1);
    wait_drain("t4");

    // 3) fill FIFO with tready low, overflow frame dropped, then drain
    tready_req = 1'b0;
    tick();
    for (int f = 0; f < 8; f++) send_frame(10 + f, 64, 8'hFF, 1'b1, 1'b1);
    send_frame(20, 64, 8'hFF, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t3 overflow count", 96'(pkt_drop_count), 96'(4));
    tready_req = 1'b1;
    wait_drain("t3");

    // 5) toggling tready across the pointer wrap
    tog_en = 1'b1;
    for (int f = 0; f < 8; f++) send_frame(30 + f, 64, (f == 7) ? 8'h3F : 8'hFF, 1'b1, 1'b1);
    wait_drain("t5");
    tog_en = 1'b0;
    repeat (2) tick();
    chk("t5 count", 96'(pkt_drop_count), 96'(4));

    // 6) asynchronous reset mid-frame
    tready_req = 1'b0;
    send_frame(40, 2, 8'hFF, 1'b1, 1'b1);
    repeat (3) tick();
    chk("t6 pre tvalid", 96'(tvalid), 96'(1));
    send_beat(mkword(41, 0), 8'hFF);
    send_beat(mkword(41, 1), 8'hFF);
    rx_data       = mkword(41, 2);
    rx_data_valid = 8'hFF;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6 rst tvalid", 96'(tvalid), 96'(0));
    chk("t6 rst tdata", 96'(tdata), 96'(0));
    chk("t6 rst tstrb", 96'(tstrb), 96'(0));
    chk("t6 rst tlast", 96'(tlast), 96'(0));
    chk("t6 rst count", 96'(pkt_drop_count), 96'(0));
    tick();
    send_beat(mkword(41, 3), 8'hFF);
    #2;
    reset_n = 1'b1;
    tready_req = 1'b1;
    #1;
    send_beat(mkword(41, 4), 8'hFF);
    send_beat(mkword(41, 5), 8'h0F);
    pulse(1'b1, 1'b0);
    tick();
    send_frame(42, 3, 8'h07, 1'b1, 1'b1);
    wait_drain("t6");
    chk("t6 count", 96'(pkt_drop_count), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
